mem_bus_arbiter: RTL and testbench

- Two-master Wishbone arbiter in front of the memory bus switch slave port, feeding the on-chip RAM path.
- Master 0 is the BIU memory port. Master 1 is a second bus master, such as a DMA engine or debug loader.
- Grants one master at a time and muxes its request to the single slave port. Routes the ack back to the granted master only.
- Sequenced by a registered grant FSM with round-robin or fixed priority.

---
 rtl/mem_bus_arbiter.sv | 144 ++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// Two-master Wishbone arbiter (round-robin or fixed priority) in front of the RAM slave port.
// Define ARB_TIMEOUT_EN to add a per-transfer ack timeout reported on m*_err_o.
module mem_bus_arbiter #(
  parameter int unsigned AW             = 32,
  parameter int unsigned DW             = 32,
  parameter int unsigned PRIORITY_MODE  = 0,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            m0_stb_i,
  input  logic            m0_we_i,
  input  logic [AW-1:0]   m0_adr_i,
  input  logic [DW-1:0]   m0_dat_i,
  input  logic [DW/8-1:0] m0_sel_i,
  output logic [DW-1:0]   m0_dat_o,
  output logic            m0_ack_o,
  output logic            m0_err_o,
  input  logic            m1_stb_i,
  input  logic            m1_we_i,
  input  logic [AW-1:0]   m1_adr_i,
  input  logic [DW-1:0]   m1_dat_i,
  input  logic [DW/8-1:0] m1_sel_i,
  output logic [DW-1:0]   m1_dat_o,
  output logic            m1_ack_o,
  output logic            m1_err_o,
  output logic            s_cyc_o,
  output logic            s_stb_o,
  output logic            s_we_o,
  output logic [AW-1:0]   s_adr_o,
  output logic [DW-1:0]   s_dat_o,
  output logic [DW/8-1:0] s_sel_o,
  input  logic [DW-1:0]   s_dat_i,
  input  logic            s_ack_i,
  output logic [1:0]      gnt_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;
  logic   r_last_grant;
  logic   w_last_grant_nxt;
  logic   w_tmo_hit;

  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;

`ifdef ARB_TIMEOUT_EN
  logic [7:0] r_tmo_cnt;

  // Counts granted cycles without ack; any state change (entry or exit) clears it.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_tmo_cnt <= 8'd0;
    end else if ((r_state == IDLE) || (w_state_nxt != r_state)) begin
      r_tmo_cnt <= 8'd0;
    end else begin
      r_tmo_cnt <= r_tmo_cnt + 8'd1;
    end
  end

  // Hit depends only on the count so the slave strobe never depends on s_ack_i.
  assign w_tmo_hit = (r_state != IDLE) && (r_tmo_cnt == 8'(TIMEOUT_CYCLES));
`else
  logic [7:0] w_unused_timeout;
  assign w_unused_timeout = 8'(TIMEOUT_CYCLES);
  assign w_tmo_hit        = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state      <= IDLE;
      r_last_grant <= 1'b1;
    end else begin
      r_state      <= w_state_nxt;
      r_last_grant <= w_last_grant_nxt;
    end
  end

  // Arbitration, slave mux and ack/err routing.
  always_comb begin
    w_state_nxt      = r_state;
    w_last_grant_nxt = r_last_grant;
    s_cyc_o          = 1'b0;
    s_stb_o          = 1'b0;
    s_we_o           = 1'b0;
    s_adr_o          = '0;
    s_dat_o          = '0;
    s_sel_o          = '0;
    m0_ack_o         = 1'b0;
    m1_ack_o         = 1'b0;
    m0_err_o         = 1'b0;
    m1_err_o         = 1'b0;
    gnt_o            = 2'b00;
    case (r_state)
      IDLE: begin
        if (m0_stb_i && m1_stb_i) begin
          w_state_nxt = ((PRIORITY_MODE == 1) || r_last_grant) ? GNT0 : GNT1;
        end else if (m0_stb_i) begin
          w_state_nxt = GNT0;
        end else if (m1_stb_i) begin
          w_state_nxt = GNT1;
        end
      end
      GNT0: begin
        gnt_o    = 2'b01;
        s_cyc_o  = m0_stb_i && !w_tmo_hit;
        s_stb_o  = m0_stb_i && !w_tmo_hit;
        s_we_o   = m0_we_i;
        s_adr_o  = m0_adr_i;
        s_dat_o  = m0_dat_i;
        s_sel_o  = m0_sel_i;
        m0_ack_o = s_ack_i;
        m0_err_o = w_tmo_hit && m0_stb_i && !s_ack_i;
        if (s_ack_i || !m0_stb_i || w_tmo_hit) begin
          w_state_nxt      = IDLE;
          w_last_grant_nxt = 1'b0;
        end
      end
      GNT1: begin
        gnt_o    = 2'b10;
        s_cyc_o  = m1_stb_i && !w_tmo_hit;
        s_stb_o  = m1_stb_i && !w_tmo_hit;
        s_we_o   = m1_we_i;
        s_adr_o  = m1_adr_i;
        s_dat_o  = m1_dat_i;
        s_sel_o  = m1_sel_i;
        m1_ack_o = s_ack_i;
        m1_err_o = w_tmo_hit && m1_stb_i && !s_ack_i;
        if (s_ack_i || !m1_stb_i || w_tmo_hit) begin
          w_state_nxt      = IDLE;
          w_last_grant_nxt = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: round-robin instance A plus fixed-priority instance B.
// Expectations follow ARB_TIMEOUT_EN the same way the design does.
module tb_mem_bus_arbiter;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned SW = DW / 8;

  typedef struct {
    int            kind;  // 0 grant, 1 ack, 2 err
    int            who;
    int            cyc;
    logic [AW-1:0] adr;
    logic          we;
    logic [DW-1:0] dat;
    logic [SW-1:0] sel;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          m0_stb = 1'b0, m0_we = 1'b0, m1_stb = 1'b0, m1_we = 1'b0;
  logic [AW-1:0] m0_adr = '0, m1_adr = '0;
  logic [DW-1:0] m0_dat = '0, m1_dat = '0, s_dat = '0;
  logic [SW-1:0] m0_sel = '1, m1_sel = '1;
  logic          man_ack = 1'b0, main_auto = 1'b0, fp_en = 1'b0;
  int            cyc = 0;
  int            n_chk = 0, n_fail = 0;
  exp_t          qa[$];
  exp_t          qb[$];

  logic [DW-1:0] a_m0_dat, a_m1_dat, a_s_dat, b_m0_dat, b_m1_dat, b_s_dat;
  logic          a_m0_ack, a_m0_err, a_m1_ack, a_m1_err, a_s_cyc, a_s_stb, a_s_we, a_s_ack;
  logic          b_m0_ack, b_m0_err, b_m1_ack, b_m1_err, b_s_cyc, b_s_stb, b_s_we, b_s_ack;
  logic [AW-1:0] a_s_adr, b_s_adr;
  logic [SW-1:0] a_s_sel, b_s_sel;
  logic [1:0]    a_gnt, b_gnt, a_gnt_prev = 2'b00, b_gnt_prev = 2'b00;

  assign a_s_ack = main_auto ? a_s_stb : man_ack;
  assign b_s_ack = b_s_stb;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_bus_arbiter #(.AW(AW), .DW(DW), .PRIORITY_MODE(0), .TIMEOUT_CYCLES(8)) u_dut_a (
    .clk_i(clk), .rst_i(rst_n),
    .m0_stb_i(m0_stb), .m0_we_i(m0_we), .m0_adr_i(m0_adr), .m0_dat_i(m0_dat), .m0_sel_i(m0_sel),
    .m0_dat_o(a_m0_dat), .m0_ack_o(a_m0_ack), .m0_err_o(a_m0_err),
    .m1_stb_i(m1_stb), .m1_we_i(m1_we), .m1_adr_i(m1_adr), .m1_dat_i(m1_dat), .m1_sel_i(m1_sel),
    .m1_dat_o(a_m1_dat), .m1_ack_o(a_m1_ack), .m1_err_o(a_m1_err),
    .s_cyc_o(a_s_cyc), .s_stb_o(a_s_stb), .s_we_o(a_s_we), .s_adr_o(a_s_adr), .s_dat_o(a_s_dat),
    .s_sel_o(a_s_sel), .s_dat_i(s_dat), .s_ack_i(a_s_ack), .gnt_o(a_gnt));

  mem_bus_arbiter #(.AW(AW), .DW(DW), .PRIORITY_MODE(1), .TIMEOUT_CYCLES(8)) u_dut_b (
    .clk_i(clk), .rst_i(rst_n),
    .m0_stb_i(m0_stb), .m0_we_i(m0_we), .m0_adr_i(m0_adr), .m0_dat_i(m0_dat), .m0_sel_i(m0_sel),
    .m0_dat_o(b_m0_dat), .m0_ack_o(b_m0_ack), .m0_err_o(b_m0_err),
    .m1_stb_i(m1_stb), .m1_we_i(m1_we), .m1_adr_i(m1_adr), .m1_dat_i(m1_dat), .m1_sel_i(m1_sel),
    .m1_dat_o(b_m1_dat), .m1_ack_o(b_m1_ack), .m1_err_o(b_m1_err),
    .s_cyc_o(b_s_cyc), .s_stb_o(b_s_stb), .s_we_o(b_s_we), .s_adr_o(b_s_adr), .s_dat_o(b_s_dat),
    .s_sel_o(b_s_sel), .s_dat_i(s_dat), .s_ack_i(b_s_ack), .gnt_o(b_gnt));

  function automatic exp_t mk(input int kind, input int who, input int c, input logic [AW-1:0] adr,
                              input logic we, input logic [DW-1:0] dat, input logic [SW-1:0] sel);
    exp_t e;
    e.kind = kind; e.who = who; e.cyc = c; e.adr = adr; e.we = we; e.dat = dat; e.sel = sel;
    return e;
  endfunction

  function automatic int who_of(input logic a0, input logic a1);
    return (a0 && a1) ? 2 : (a1 ? 1 : 0);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0h, expected %0h", nm, cyc, act, exp);
    end
  endtask

  task automatic unexp(input string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s: unexpected event at cyc %0d", nm, cyc);
  endtask

  task automatic chk_evt(input string nm, input exp_t e, input int kind, input int who,
                         input logic [AW-1:0] adr, input logic we, input logic [DW-1:0] dat,
                         input logic [SW-1:0] sel);
    logic bad;
    n_chk++;
    bad = (e.kind != kind) || (e.who != who) || (e.cyc != cyc);
    if (kind == 0) bad = bad || (adr !== e.adr) || (we !== e.we) || (dat !== e.dat) || (sel !== e.sel);
    if (kind == 1) bad = bad || (dat !== e.dat);
    if (bad) begin
      n_fail++;
      $display("FAIL %s: got kind=%0d who=%0d cyc=%0d adr=%h we=%b dat=%h sel=%h, expected kind=%0d who=%0d cyc=%0d adr=%h we=%b dat=%h sel=%h",
               nm, kind, who, cyc, adr, we, dat, sel, e.kind, e.who, e.cyc, e.adr, e.we, e.dat, e.sel);
    end
  endtask

  // Monitor for the round-robin instance: every grant start, ack and err pops the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (a_gnt != 2'b00 && a_gnt_prev == 2'b00) begin
      chk("A cyc_eq_stb", {63'd0, a_s_cyc}, {63'd0, a_s_stb});
      if (qa.size() == 0) unexp("A grant");
      else begin
        e = qa.pop_front();
        chk_evt("A grant", e, 0, (a_gnt == 2'b01) ? 0 : ((a_gnt == 2'b10) ? 1 : 2),
                a_s_adr, a_s_we, a_s_dat, a_s_sel);
      end
    end
    if (a_m0_ack || a_m1_ack) begin
      if (qa.size() == 0) unexp("A ack");
      else begin
        e = qa.pop_front();
        chk_evt("A ack", e, 1, who_of(a_m0_ack, a_m1_ack), '0, 1'b0, a_m1_ack ? a_m1_dat : a_m0_dat, '0);
      end
    end
    if (a_m0_err || a_m1_err) begin
      if (qa.size() == 0) unexp("A err");
      else begin
        e = qa.pop_front();
        chk_evt("A err", e, 2, who_of(a_m0_err, a_m1_err), '0, 1'b0, '0, '0);
      end
    end
    a_gnt_prev <= a_gnt;
  end

  // Monitor for the fixed-priority instance, active only during the contention window.
  always @(negedge clk) begin
    exp_t e;
    if (fp_en && b_gnt != 2'b00 && b_gnt_prev == 2'b00) begin
      chk("B cyc_eq_stb", {63'd0, b_s_cyc}, {63'd0, b_s_stb});
      if (qb.size() == 0) unexp("B grant");
      else begin
        e = qb.pop_front();
        chk_evt("B grant", e, 0, (b_gnt == 2'b01) ? 0 : ((b_gnt == 2'b10) ? 1 : 2),
                b_s_adr, b_s_we, b_s_dat, b_s_sel);
      end
    end
    if (fp_en && (b_m0_ack || b_m1_ack || b_m0_err || b_m1_err)) begin
      if (qb.size() == 0) unexp("B ack");
      else begin
        e = qb.pop_front();
        chk_evt("B ack", e, (b_m0_err || b_m1_err) ? 2 : 1, who_of(b_m0_ack, b_m1_ack), '0, 1'b0,
                b_m1_ack ? b_m1_dat : b_m0_dat, '0);
      end
    end
    b_gnt_prev <= b_gnt;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int t;
    #2;
    chk("rst gnt", {62'd0, a_gnt}, 64'd0);
    chk("rst s_cyc_stb_we", {61'd0, a_s_cyc, a_s_stb, a_s_we}, 64'd0);
    chk("rst s_adr", {32'd0, a_s_adr}, 64'd0);
    chk("rst ack_err", {60'd0, a_m0_ack, a_m1_ack, a_m0_err, a_m1_err}, 64'd0);
    tick(); tick();
    rst_n = 1'b1;
    tick(); tick();

    // m0 read of 0x10, slave acks two cycles after s_stb_o
    t = cyc;
    m0_adr = 32'h10; m0_we = 1'b0; m0_dat = '0; m0_sel = 4'hF; m0_stb = 1'b1;
    qa.push_back(mk(0, 0, t + 1, 32'h10, 1'b0, '0, 4'hF));
    @(negedge clk);
    chk("arb latency s_stb", {63'd0, a_s_stb}, 64'd0);
    tick(); tick(); tick();
    s_dat = 32'hDEAD_BEEF; man_ack = 1'b1;
    qa.push_back(mk(1, 0, t + 3, '0, 1'b0, 32'hDEAD_BEEF, '0));
    tick();
    man_ack = 1'b0; m0_stb = 1'b0;
    tick(); tick();

    // m1 write held while m0 requests mid-transfer
    t = cyc;
    m1_we = 1'b1; m1_adr = 32'h100; m1_dat = 32'h1234_5678; m1_sel = 4'b0011; m1_stb = 1'b1;
    qa.push_back(mk(0, 1, t + 1, 32'h100, 1'b1, 32'h1234_5678, 4'b0011));
    tick(); tick();
    m0_stb = 1'b1; m0_adr = 32'h200; m0_we = 1'b0; m0_dat = 32'hA5A5_A5A5; m0_sel = 4'hF;
    @(negedge clk);
    chk("hold s_adr", {32'd0, a_s_adr}, 64'h100);
    chk("hold s_dat", {32'd0, a_s_dat}, 64'h1234_5678);
    chk("hold s_sel_we", {59'd0, a_s_sel, a_s_we}, {59'd0, 4'b0011, 1'b1});
    chk("hold gnt", {62'd0, a_gnt}, 64'd2);
    tick();
    man_ack = 1'b1; s_dat = 32'h0BAD_F00D;
    qa.push_back(mk(1, 1, t + 3, '0, 1'b0, 32'h0BAD_F00D, '0));
    @(negedge clk);
    chk("hold s_adr at ack", {32'd0, a_s_adr}, 64'h100);
    tick();
    man_ack = 1'b0; m1_stb = 1'b0;
    qa.push_back(mk(0, 0, t + 5, 32'h200, 1'b0, 32'hA5A5_A5A5, 4'hF));
    @(negedge clk);
    chk("idle gap gnt", {62'd0, a_gnt}, 64'd0);
    tick();
    man_ack = 1'b1;
    qa.push_back(mk(1, 0, t + 5, '0, 1'b0, 32'h0BAD_F00D, '0));
    tick();
    man_ack = 1'b0; m0_stb = 1'b0;
    tick();

    // m1 transfer, m0 request in the ack cycle, m0 abort, then a tie
    t = cyc;
    m1_we = 1'b0; m1_adr = 32'h300; m1_dat = '0; m1_sel = 4'hF; m1_stb = 1'b1;
    m0_dat = '0;
    qa.push_back(mk(0, 1, t + 1, 32'h300, 1'b0, '0, 4'hF));
    tick();
    man_ack = 1'b1; m0_stb = 1'b1; m0_adr = 32'h40;
    qa.push_back(mk(1, 1, t + 1, '0, 1'b0, 32'h0BAD_F00D, '0));
    qa.push_back(mk(0, 0, t + 3, 32'h40, 1'b0, '0, 4'hF));
    tick();
    man_ack = 1'b0; m1_stb = 1'b0;
    tick(); tick();
    m0_stb = 1'b0;
    @(negedge clk);
    chk("abort gnt", {62'd0, a_gnt}, 64'd1);
    chk("abort s_stb", {63'd0, a_s_stb}, 64'd0);
    tick();
    m0_adr = 32'h44; m1_adr = 32'h304; m0_stb = 1'b1; m1_stb = 1'b1;
    qa.push_back(mk(0, 1, t + 6, 32'h304, 1'b0, '0, 4'hF));
    tick();
    man_ack = 1'b1;
    qa.push_back(mk(1, 1, t + 6, '0, 1'b0, 32'h0BAD_F00D, '0));
    tick();
    man_ack = 1'b0; m0_stb = 1'b0; m1_stb = 1'b0;
    tick();

    // reset asserted while m0 is granted and the slave is acking
    t = cyc;
    m0_adr = 32'h80; m0_stb = 1'b1;
    qa.push_back(mk(0, 0, t + 1, 32'h80, 1'b0, '0, 4'hF));
    tick(); tick();
    rst_n = 1'b0; man_ack = 1'b1;
    @(negedge clk);
    chk("midrst gnt", {62'd0, a_gnt}, 64'd0);
    chk("midrst s_cyc_stb", {62'd0, a_s_cyc, a_s_stb}, 64'd0);
    chk("midrst ack_err", {62'd0, a_m0_ack, a_m0_err}, 64'd0);
    chk("midrst s_adr", {32'd0, a_s_adr}, 64'd0);
    tick();
    m0_stb = 1'b0; man_ack = 1'b0;
    tick();
    rst_n = 1'b1;
    tick(); tick();

    // continuous contention, zero-wait slave: A alternates, B (fixed priority) starves m1
    t = cyc;
    main_auto = 1'b1; fp_en = 1'b1;
    m0_adr = 32'hA0; m1_adr = 32'hB0; s_dat = 32'hCAFE_0001;
    m0_stb = 1'b1; m1_stb = 1'b1;
    for (int k = 0; k < 4; k++) begin
      qa.push_back(mk(0, k % 2, t + 1 + 2 * k, (k % 2 == 1) ? 32'hB0 : 32'hA0, 1'b0, '0, 4'hF));
      qa.push_back(mk(1, k % 2, t + 1 + 2 * k, '0, 1'b0, 32'hCAFE_0001, '0));
      qb.push_back(mk(0, 0, t + 1 + 2 * k, 32'hA0, 1'b0, '0, 4'hF));
      qb.push_back(mk(1, 0, t + 1 + 2 * k, '0, 1'b0, 32'hCAFE_0001, '0));
    end
    repeat (8) tick();
    m0_stb = 1'b0; m1_stb = 1'b0;
    tick();
    fp_en = 1'b0; main_auto = 1'b0;
    tick();

    // m0 granted, slave never acks
    t = cyc;
    m0_adr = 32'hC0; m0_stb = 1'b1;
    qa.push_back(mk(0, 0, t + 1, 32'hC0, 1'b0, '0, 4'hF));
`ifdef ARB_TIMEOUT_EN
    qa.push_back(mk(2, 0, t + 9, '0, 1'b0, '0, '0));
    repeat (9) tick();
    @(negedge clk);
    chk("timeout s_cyc", {63'd0, a_s_cyc}, 64'd0);
    chk("timeout gnt", {62'd0, a_gnt}, 64'd1);
    tick();
    m0_stb = 1'b0;
    @(negedge clk);
    chk("after timeout gnt", {62'd0, a_gnt}, 64'd0);
    tick();
`else
    repeat (10) tick();
    @(negedge clk);
    chk("no timeout gnt", {62'd0, a_gnt}, 64'd1);
    chk("no timeout s_cyc", {63'd0, a_s_cyc}, 64'd1);
    chk("no timeout err", {63'd0, a_m0_err}, 64'd0);
    tick();
    m0_stb = 1'b0;
    tick();
    @(negedge clk);
    chk("release gnt", {62'd0, a_gnt}, 64'd0);
    tick();
`endif
    tick(); tick();
    chk("A pending expectations", 64'(qa.size()), 64'd0);
    chk("B pending expectations", 64'(qb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
